// File: rtl/spi_out.sv
// SPI mode-0 master: streams FRAME_WORDS 16-bit words, MSB first, from a
// synchronous-read word memory as a single chip-select-low burst.
module spi_out #(
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int FRAME_WORDS       = 16,
    parameter int CLK_DIV           = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDRESS_BUS_WIDTH:0] read_address,
    input  logic [15:0]                read_data,
    output logic                       cs,
    output logic                       sck,
    output logic                       mosi
);

    localparam int              AW         = ADDRESS_BUS_WIDTH + 1;
    localparam int              DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [AW-1:0]   LAST_WORD  = AW'(FRAME_WORDS - 1);
    localparam logic [DW-1:0]   DIV_LAST   = DW'(CLK_DIV - 1);
    localparam bit              MULTI_WORD = (FRAME_WORDS > 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        TAIL
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  addr_q;
    logic [AW-1:0]  word_q;
    logic [3:0]     bit_q;
    logic [DW-1:0]  div_q;
    logic [15:0]    shift_q;
    logic           cs_q;
    logic           sck_q;
    logic           busy_q;
    logic           done_q;

    logic           div_end;
    logic [AW-1:0]  word_d;
    logic [15:0]    shift_d;

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        div_end = (div_q == DIV_LAST);
        word_d  = word_q + 1'b1;
        shift_d = {shift_q[14:0], 1'b0};
    end

    // mosi is the shift register MSB, so it only moves when shift_q is loaded or shifted.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cs_q  <= 1'b1;
                    sck_q <= 1'b0;
                    if (start) begin
                        addr_q  <= '0;
                        word_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    shift_q <= read_data;
                    cs_q    <= 1'b0;
                    sck_q   <= 1'b0;
                    bit_q   <= 4'd15;
                    div_q   <= '0;
                    if (MULTI_WORD) begin
                        addr_q <= AW'(1);
                    end
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q != 4'd0) begin
                                shift_q <= shift_d;
                                bit_q   <= bit_q - 4'd1;
                            end else if (word_q != LAST_WORD) begin
                                // Word boundary: the prefetched word is already on read_data.
                                shift_q <= read_data;
                                bit_q   <= 4'd15;
                                word_q  <= word_d;
                                if (word_d != LAST_WORD) begin
                                    addr_q <= word_d + 1'b1;
                                end
                            end else begin
                                shift_q <= '0;
                                state_q <= TAIL;
                            end
                        end
                    end
                end
                TAIL: begin
                    if (!div_end) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q   <= '0;
                        cs_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign read_address = addr_q;
    assign cs           = cs_q;
    assign sck          = sck_q;
    assign mosi         = shift_q[15];

endmodule

// File: doc/spi_out.md
# spi_out

SPI bus master that streams a fixed-length frame of 16-bit words from a synchronous-read word memory onto `cs`/`sck`/`mosi`. It is the transmitting end of the `spi_in` link and drives exactly the format `spi_in` consumes:

- mode 0, MSB first, 16-bit words;
- one `cs`-low burst per frame;
- first word lands at receiver address 0.

It sits in the system clock domain between a frame buffer and the board-to-board SPI pins.

## Interface

Parameters:
- `ADDRESS_BUS_WIDTH`, 12: memory address is `ADDRESS_BUS_WIDTH+1` bits, matching `spi_in`.
- `FRAME_WORDS`, 16: words per frame; legal range is 1 to 2^(ADDRESS_BUS_WIDTH+1).
- `CLK_DIV`, 2: `sck` half-period in `clk` cycles; must be at least 1.

Ports:
- `clk`  input  1: system clock; every register uses its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request one frame; sampled only in IDLE.
- `busy`  output  1: high while a frame is in progress.
- `done`  output  1: one-cycle pulse when the frame completes.
- `read_address`  output  `ADDRESS_BUS_WIDTH+1`: memory word address, registered.
- `read_data`  input  16: memory word, valid one `clk` cycle after `read_address` changes.
- `cs`  output  1: chip select, active low, registered.
- `sck`  output  1: serial clock, idles low, registered.
- `mosi`  output  1: serial data, registered.

## Operation

Reset values: `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `read_address`=0. Internal state is IDLE, with the word counter, bit counter and divider counter all cleared.

States:
- **IDLE**
  - `cs`=1, `sck`=0, `busy`=0.
  - On `start`=1: `read_address`<=0, word counter<=0, go to FETCH.
- **FETCH**
  - One cycle, to cover memory read latency.
  - Go to LOAD.
- **LOAD**
  - One cycle.
  - shift register<=`read_data`, `cs`<=0, `mosi`<=`read_data[15]`, bit counter<=15.
  - If `FRAME_WORDS`>1, `read_address`<=1 (prefetch). Go to SHIFT, low phase.
- **SHIFT**
  - Low phase: `sck`=0 for `CLK_DIV` cycles. Then `sck`<=1.
  - High phase: `sck`=1 for `CLK_DIV` cycles. At the end of the high phase `sck`<=0, and:
    - If bit counter>0: shift left, `mosi`<=next bit, bit counter decrements.
    - If bit counter=0 and this is not the last word: shift register<=`read_data` (prefetched), `mosi`<=`read_data[15]`, bit counter<=15, word counter increments. `read_address` increments only if another word remains after this one.
    - If bit counter=0 and this is the last word: `mosi`<=0, go to TAIL.
- **TAIL**
  - `cs`=0, `sck`=0 for `CLK_DIV` cycles.
  - Then `cs`<=1, `done`<=1 for one cycle, go to IDLE.

Rules:
- `mosi` changes only on the same edge where `sck` falls, or in LOAD while `sck` is low. It is therefore stable for at least `CLK_DIV` cycles before each `sck` rise.
- `cs` stays low continuously for the whole frame. There are no inter-word gaps in `cs` or in `sck` cadence.
- `read_address` never exceeds `FRAME_WORDS-1` during a frame. It holds its last value in IDLE until the next `start`.
- `busy` is a registered decode of state≠IDLE.

## Timing

- `start` sampled at edge 0. `busy` rises at edge 0 and falls at the edge where `done` rises.
- `busy` high time is exactly 2 + 32·`FRAME_WORDS`·`CLK_DIV` + `CLK_DIV` cycles.
- First `sck` rise occurs `CLK_DIV` cycles after `cs` falls.
- Last `sck` fall to `cs` rise is `CLK_DIV` cycles.
- Memory word k+1 is addressed at least 32·`CLK_DIV`-1 cycles before it is consumed.
- `start` while busy is ignored, with no queuing.
- `start` is accepted in the same IDLE cycle that `done` is high. Back-to-back frames therefore have `cs` high for exactly 3 cycles.
- `rst` asserted mid-frame takes effect immediately, without waiting for `clk`: `cs` goes high and `sck` low, which aborts the receiver's word. After release, the block stays in IDLE until a new `start`.

## Test plan

- **Reset:** assert `rst` with toggling inputs. Require `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `read_address`=0 with no `clk` edge.
- **Single word:** `FRAME_WORDS`=1, `CLK_DIV`=1, memory[0]=16'hA55A, pulse `start`. Require:
  - exactly 16 `sck` rises;
  - `mosi` sampled at the rises gives 16'hA55A, MSB first;
  - `busy` high for 35 cycles;
  - one `done` pulse.
- **Multi-word loopback:** `FRAME_WORDS`=3, `CLK_DIV`=2, memory={16'h1234, 16'hABCD, 16'h0F0F}, output looped into `spi_in`. Require:
  - receiver writes (0,1234), (1,ABCD), (2,0F0F);
  - 48 `sck` rises within one `cs`-low span;
  - `read_address` sequence 0,1,2 and never 3;
  - `busy` high for 196 cycles.
- **Start handling:** pulse `start` mid-frame and require it to be ignored. Then hold `start` high across `done` and require a second frame to begin with `cs` high for exactly 3 cycles.
- **Reset mid-word:** assert `rst` after 7 `sck` rises of word 0. Require `cs`=1 and `sck`=0 immediately. After release and a fresh `start`, require a complete frame from address 0.
